// File: rtl/link_tx_sync.sv
`default_nettype none
// ============================================================================
// Module   : link_tx_sync
// Purpose  : Clocked injector of words into a two-phase dual-rail link.
// Revision : 1.0 - initial release
// ============================================================================
module link_tx_sync #(
   parameter int REG_WIDTH = 8,
   parameter int TIMEOUT   = 1024,
   parameter int CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_s_valid,
   input  logic [REG_WIDTH-1:0]     i_s_data,
   output logic                     o_s_ready,
   output logic [2*REG_WIDTH-1:0]   o_out_data,
   input  logic                     i_out_ack,
   output logic                     o_busy,
   output logic [CNT_WIDTH-1:0]     o_tx_count,
   output logic                     o_err_timeout,
   output logic                     o_err_spurious
);

   localparam int            c_TW       = $clog2(TIMEOUT + 1);
   localparam logic [c_TW-1:0] c_TMO_MAX  = c_TW'(TIMEOUT);
   localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic                     r_live;
   logic                     r_sync1;
   logic                     r_sync2;
   logic                     r_ack_phase;
   logic [2*REG_WIDTH-1:0]   r_rails;
   logic [c_TW-1:0]          r_tmo;
   logic [CNT_WIDTH-1:0]     r_tx_count;
   logic                     r_err_timeout;
   logic                     r_err_spurious;
   logic [2*REG_WIDTH-1:0]   w_mask;
   logic                     w_ack_new;
   logic                     w_accept;
   logic                     w_consume;
   logic                     w_spurious;

   // One toggle per rail pair: true rail for a 1, false rail for a 0.
   for (genvar gi = 0; gi < REG_WIDTH; gi++) begin : g_mask
      assign w_mask[2*gi]   = ~i_s_data[gi];
      assign w_mask[2*gi+1] =  i_s_data[gi];
   end

   assign w_ack_new = r_sync2 ^ r_ack_phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_consume   = 1'b0;
      w_spurious  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_spurious = w_ack_new;
            if (r_live && i_s_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_ack_new) begin
               w_consume   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // r_live keeps s_ready low until the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_live         <= 1'b0;
         r_sync1        <= 1'b0;
         r_sync2        <= 1'b0;
         r_ack_phase    <= 1'b0;
         r_rails        <= '0;
         r_tmo          <= '0;
         r_tx_count     <= '0;
         r_err_timeout  <= 1'b0;
         r_err_spurious <= 1'b0;
      end else begin
         r_live  <= 1'b1;
         r_sync1 <= i_out_ack;
         r_sync2 <= r_sync1;
         if (w_ack_new) begin
            r_ack_phase <= r_sync2;
         end
         if (w_accept) begin
            r_rails <= r_rails ^ w_mask;
            r_tmo   <= '0;
         end else if ((r_state == ST_WAIT) && (r_tmo != c_TMO_MAX)) begin
            r_tmo <= r_tmo + c_TW'(1);
         end
         if ((r_state == ST_WAIT) && (r_tmo == c_TMO_LAST)) begin
            r_err_timeout <= 1'b1;
         end
         if (w_consume) begin
            r_tx_count <= r_tx_count + CNT_WIDTH'(1);
         end
         if (w_spurious) begin
            r_err_spurious <= 1'b1;
         end
      end
   end

   assign o_s_ready      = (r_state == ST_IDLE) && r_live;
   assign o_busy         = (r_state == ST_WAIT);
   assign o_out_data     = r_rails;
   assign o_tx_count     = r_tx_count;
   assign o_err_timeout  = r_err_timeout;
   assign o_err_spurious = r_err_spurious;

endmodule
`default_nettype wire
